// File: rtl/ebpc_input_serializer.sv
// Splits wide input words into DATA_W elements for the EBPC encoder.
// Emits exactly cfg_len elements per stream and flags the final one with last_o.
module ebpc_input_serializer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned N_WORDS = 4,
  parameter int unsigned LEN_W   = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [LEN_W-1:0]          cfg_len_i,
  input  logic                      cfg_vld_i,
  output logic                      cfg_rdy_o,
  input  logic [N_WORDS*DATA_W-1:0] in_data_i,
  input  logic                      in_vld_i,
  output logic                      in_rdy_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      last_o,
  output logic                      vld_o,
  input  logic                      rdy_i,
  output logic                      idle_o
);

  localparam int unsigned IN_W   = N_WORDS * DATA_W;
  localparam int unsigned LANE_W = $clog2(N_WORDS);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IN_W-1:0]     word_q, word_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                in_rdy_c;
  logic                vld_d;
  logic                last_d;
  logic [DATA_W-1:0]   data_d;

  // State register; output registers are loaded from the next-state view
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      word_q  <= '0;
      lane_q  <= '0;
      rem_q   <= '0;
      vld_o   <= 1'b0;
      last_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      rem_q   <= rem_d;
      vld_o   <= vld_d;
      last_o  <= last_d;
      data_o  <= data_d;
    end
  end

  // Next-state logic and handshake decode
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    lane_d   = lane_q;
    rem_d    = rem_q;
    in_rdy_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A zero-length config is consumed without starting a stream
        if (cfg_vld_i && (cfg_len_i != '0)) begin
          rem_d   = cfg_len_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        in_rdy_c = 1'b1;
        if (in_vld_i) begin
          word_d  = in_data_i;
          lane_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rdy_i) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
          end else if (lane_q != LAST_LANE) begin
            lane_d = lane_q + LANE_W'(1);
          end else begin
            // Word exhausted: refill in the same cycle to avoid a bubble
            in_rdy_c = 1'b1;
            if (in_vld_i) begin
              word_d = in_data_i;
              lane_d = '0;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    vld_d  = (state_d == SHIFT);
    last_d = (state_d == SHIFT) && (rem_d == LEN_W'(1));
    data_d = word_d[int'(lane_d)*DATA_W +: DATA_W];
  end

  assign in_rdy_o  = in_rdy_c;
  assign cfg_rdy_o = (state_q == IDLE);
  assign idle_o    = (state_q == IDLE);

endmodule

// File: doc/ebpc_input_serializer.md
Name: ebpc_input_serializer

Overview:
- Upstream feeder of the EBPC encoder.
- Accepts a per-stream length configuration, then wide input words, each packing N_WORDS elements of DATA_W bits.
- Emits one DATA_W element per beat on a valid/ready stream, with last asserted on the final configured element. This output drives the encoder's data/last/vld/rdy input directly.
- Lanes of the final input word beyond the configured length are discarded.

Parameters:
DATA_W, 8, element width in bits; must equal the encoder's DATA_W.
N_WORDS, 4, elements per input word (power of two, >=2); input width is N_WORDS*DATA_W.
LEN_W, 24, width of the element-count configuration.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
cfg_len_i  in  LEN_W  number of DATA_W elements in the next stream
cfg_vld_i  in  1  configuration valid
cfg_rdy_o  out  1  configuration ready
in_data_i  in  N_WORDS*DATA_W  packed input word; element k at bits [k*DATA_W +: DATA_W], lane 0 emitted first
in_vld_i  in  1  input word valid
in_rdy_o  out  1  input word ready
data_o  out  DATA_W  output element
last_o  out  1  final element of stream
vld_o  out  1  output valid
rdy_i  in  1  output ready
idle_o  out  1  no stream in progress

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE, word_q=0, lane_q=0, rem_q=0, vld_o=0, last_o=0, data_o=0, in_rdy_o=0, cfg_rdy_o=1, idle_o=1.
- Handshakes:
  - A transfer occurs on the cycle where vld and rdy are both high.
  - Once vld_o is high, data_o/last_o/vld_o hold stable until accepted.
  - vld_o, data_o and last_o are driven from registers only.
  - in_rdy_o may depend combinationally on rdy_i.
- State IDLE:
  - Outputs: cfg_rdy_o=1, idle_o=1, in_rdy_o=0, vld_o=0.
  - Config accept with cfg_len_i>=1: rem_q<=cfg_len_i, go to LOAD.
  - Config accept with cfg_len_i=0: accepted and dropped, no input consumed, no output, stay IDLE.
- State LOAD:
  - Outputs: in_rdy_o=1, cfg_rdy_o=0, idle_o=0.
  - Input accept: word_q<=in_data_i, lane_q<=0, go to SHIFT.
- State SHIFT:
  - Outputs: vld_o=1, data_o=lane lane_q of word_q, last_o=(rem_q==1).
  - On output accept, rem_q decrements.
  - If rem_q==1: go to IDLE. Remaining lanes of word_q are dropped.
  - Else if lane_q<N_WORDS-1: lane_q increments.
  - Else (word exhausted, more elements remain): in_rdy_o=1 in that same cycle, so in_rdy_o = rdy_i && lane_q==N_WORDS-1 && rem_q>1.
    - If in_vld_i: load word_q, lane_q<=0, stay SHIFT (zero-bubble).
    - Else: go to LOAD.
- Latency and throughput:
  - Input word accepted at cycle t gives lane 0 on vld_o at t+1.
  - Sustained rate is one element per cycle with in_vld_i and rdy_i held high.
- Config during a stream: cfg_rdy_o=0 outside IDLE. The next config is accepted only in IDLE, one cycle after last is accepted.
- Counter widths and lengths:
  - rem_q is LEN_W bits.
  - lane_q is clog2(N_WORDS) bits and wraps only via explicit reset to 0 on load.
  - Maximum length 2^LEN_W-1 elements.
- Input beyond the configured length: not consumed. It stays pending on the input handshake for the next stream.
- Reset mid-stream:
  - All state returns to reset values immediately (asynchronous).
  - The partially emitted stream is abandoned, with no last.
  - A word held in word_q is lost.

Test Plan:
- N_WORDS=4, cfg_len=6, words W0=0x44332211, W1=0x88776655 -> data_o 11,22,33,44,55,66; last_o only on 66; 77/88 dropped; returns to IDLE with idle_o=1.
- cfg_len=1, W0=0xDDCCBBAA -> single beat AA with last_o=1; exactly one input word consumed.
- cfg_len=0 -> cfg accepted, in_rdy_o stays 0, no output beat, a following cfg_len=2 is accepted next cycle and streams normally.
- cfg_len=8, in_vld_i and rdy_i held 1 -> 8 beats in 8 consecutive cycles starting one cycle after first word accept; in_rdy_o pulses in the cycle lane 3 is accepted.
- cfg_len=5 with rdy_i toggling 1,0,0,1,... -> data_o/last_o stable while stalled; sequence and last identical to the unstalled run; no input accepted while rdy_i=0.
- rst_i pulsed during beat 3 of cfg_len=8 -> vld_o=0, idle_o=1, cfg_rdy_o=1 immediately; a new cfg_len=2 then completes normally.
